// File: rtl/xc_malu_mdu_pkg.sv
// Shared op/state encodings and op-decode helpers for the iterative mul/div unit.
package xc_malu_mdu_pkg;

   typedef enum logic [2:0] {
      MDU_OP_MUL    = 3'd0,
      MDU_OP_MULH   = 3'd1,
      MDU_OP_MULHSU = 3'd2,
      MDU_OP_MULHU  = 3'd3,
      MDU_OP_DIV    = 3'd4,
      MDU_OP_DIVU   = 3'd5,
      MDU_OP_REM    = 3'd6,
      MDU_OP_REMU   = 3'd7
   } mdu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_t;

   function automatic logic op_is_div(input mdu_op_t op);
      return op[2];
   endfunction

   // MUL's low half is sign-agnostic; treating it as signed is harmless.
   function automatic logic op_signed_rs1(input mdu_op_t op);
      return (op == MDU_OP_MUL) || (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
             (op == MDU_OP_DIV) || (op == MDU_OP_REM);
   endfunction

   function automatic logic op_signed_rs2(input mdu_op_t op);
      return (op == MDU_OP_MUL) || (op == MDU_OP_MULH) ||
             (op == MDU_OP_DIV) || (op == MDU_OP_REM);
   endfunction

   function automatic logic op_high(input mdu_op_t op);
      return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) || (op == MDU_OP_MULHU);
   endfunction

   function automatic logic op_rem(input mdu_op_t op);
      return (op == MDU_OP_REM) || (op == MDU_OP_REMU);
   endfunction

endpackage

// File: rtl/xc_malu_mdu_step.sv
// One CALC cycle: RADIX_BITS chained shift-add (multiply) or restoring-subtract (divide) stages.
module xc_malu_mdu_step #(
   parameter int XLEN       = 32,
   parameter int RADIX_BITS = 1
) (
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [XLEN-1:0]   i_opnd,
   input  logic              i_div,
   output logic [2*XLEN-1:0] o_acc
);

   // Accumulator layout: multiply {partial product, remaining multiplier bits},
   // divide {partial remainder, remaining dividend / growing quotient}.
   for (genvar g = 0; g < RADIX_BITS; g++) begin : g_stage
      logic [2*XLEN-1:0] w_in;
      logic [2*XLEN-1:0] w_out;
      logic [XLEN:0]     w_sum;
      logic [XLEN+1:0]   w_diff;
      logic              w_ge;
      logic              w_unused_diff;

      if (g == 0) begin : g_first
         assign w_in = i_acc;
      end else begin : g_chain
         assign w_in = g_stage[g-1].w_out;
      end

      assign w_sum  = {1'b0, w_in[2*XLEN-1:XLEN]} + {1'b0, i_opnd};
      assign w_diff = {1'b0, w_in[2*XLEN-1:XLEN-1]} - {2'b00, i_opnd};
      assign w_ge   = ~w_diff[XLEN+1];
      assign w_unused_diff = w_diff[XLEN];

      always_comb begin
         w_out = '0;
         if (i_div) begin
            if (w_ge) w_out = {w_diff[XLEN-1:0], w_in[XLEN-2:0], 1'b1};
            else      w_out = {w_in[2*XLEN-2:0], 1'b0};
         end else begin
            if (w_in[0]) w_out = {w_sum, w_in[XLEN-1:1]};
            else         w_out = {1'b0, w_in[2*XLEN-1:1]};
         end
      end
   end

   assign o_acc = g_stage[RADIX_BITS-1].w_out;

endmodule

// File: rtl/xc_malu_mdu.sv
// Iterative RV M-extension multiply/divide unit with valid/ready request and response.
module xc_malu_mdu
   import xc_malu_mdu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int RADIX_BITS = 1
) (
   input  logic            clock,
   input  logic            resetn,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_rs1,
   input  logic [XLEN-1:0] req_rs2,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result
);

   localparam int STEPS = XLEN / RADIX_BITS;
   localparam int CW    = $clog2(STEPS);

   mdu_state_t        r_state, w_state_nxt;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN-1:0] r_acc;
   logic [XLEN-1:0]   r_opnd;
   logic [XLEN-1:0]   r_result;
   mdu_op_t           r_op;
   logic              r_neg;

   mdu_op_t           w_op;
   logic              w_s1, w_s2, w_div0, w_ovf, w_short, w_neg;
   logic [XLEN-1:0]   w_mag1, w_mag2, w_short_res;
   logic [2*XLEN-1:0] w_step_acc, w_prod;
   logic [XLEN-1:0]   w_dsel, w_fix_res;

   // Request decode: operand magnitudes, result sign and the two shortcut cases.
   assign w_op   = mdu_op_t'(req_op);
   assign w_s1   = op_signed_rs1(w_op) & req_rs1[XLEN-1];
   assign w_s2   = op_signed_rs2(w_op) & req_rs2[XLEN-1];
   assign w_mag1 = w_s1 ? -req_rs1 : req_rs1;
   assign w_mag2 = w_s2 ? -req_rs2 : req_rs2;
   assign w_neg  = op_rem(w_op) ? w_s1 : (w_s1 ^ w_s2);
   assign w_div0 = op_is_div(w_op) && (req_rs2 == '0);
   assign w_ovf  = op_is_div(w_op) && op_signed_rs1(w_op) &&
                   (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (req_rs2 == '1);
   assign w_short = w_div0 | w_ovf;

   always_comb begin
      w_short_res = '0;
      if (w_div0) w_short_res = op_rem(w_op) ? req_rs1 : '1;
      else        w_short_res = op_rem(w_op) ? '0 : req_rs1;
   end

   xc_malu_mdu_step #(
      .XLEN       (XLEN),
      .RADIX_BITS (RADIX_BITS)
   ) u_step (
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .i_div  (op_is_div(r_op)),
      .o_acc  (w_step_acc)
   );

   // Sign fix-up: r_neg already encodes quotient vs remainder sign rules.
   assign w_prod = r_neg ? -r_acc : r_acc;
   assign w_dsel = op_rem(r_op) ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

   always_comb begin
      w_fix_res = '0;
      if (op_is_div(r_op)) w_fix_res = r_neg ? -w_dsel : w_dsel;
      else if (op_high(r_op)) w_fix_res = w_prod[2*XLEN-1:XLEN];
      else w_fix_res = w_prod[XLEN-1:0];
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (req_valid) w_state_nxt = w_short ? ST_DONE : ST_CALC;
         ST_CALC: if (r_cnt == CW'(STEPS - 1)) w_state_nxt = ST_FIX;
         ST_FIX:  w_state_nxt = ST_DONE;
         ST_DONE: if (rsp_ready) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
      if (flush) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_result <= '0;
         r_op     <= MDU_OP_MUL;
         r_neg    <= 1'b0;
      end else if (!flush) begin
         case (r_state)
            ST_IDLE: if (req_valid) begin
               r_op   <= w_op;
               r_neg  <= w_neg;
               r_cnt  <= '0;
               r_acc  <= {{XLEN{1'b0}}, op_is_div(w_op) ? w_mag1 : w_mag2};
               r_opnd <= op_is_div(w_op) ? w_mag2 : w_mag1;
               if (w_short) r_result <= w_short_res;
            end
            ST_CALC: begin
               r_acc <= w_step_acc;
               r_cnt <= r_cnt + 1'b1;
            end
            ST_FIX:  r_result <= w_fix_res;
            default: ;
         endcase
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = (r_state == ST_DONE);
   assign rsp_result = r_result;

endmodule

// File: tb/tb_xc_malu_mdu.sv
// Bench: three units (RADIX_BITS 1/2/4) exercised in turn with a scoreboard of expected results.
module tb_xc_malu_mdu;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [2:0]  req_op = '0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic        flush     [3];
   logic        req_valid [3];
   logic        rsp_ready [3];
   logic        req_ready [3];
   logic        rsp_valid [3];
   logic [31:0] rsp_result[3];

   logic [31:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      xc_malu_mdu #(.XLEN(32), .RADIX_BITS(1 << g)) u_dut (
         .clock      (clock),
         .resetn     (resetn),
         .flush      (flush[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_op     (req_op),
         .req_rs1    (rs1),
         .req_rs2    (rs2),
         .rsp_valid  (rsp_valid[g]),
         .rsp_ready  (rsp_ready[g]),
         .rsp_result (rsp_result[g])
      );
   end

   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb, za, zb, p;
      sa = $signed(a); sb = $signed(b);
      za = {32'd0, a}; zb = {32'd0, b};
      case (op)
         3'd0: p = sa * sb;
         3'd1: p = (sa * sb) >>> 32;
         3'd2: p = (sa * zb) >>> 32;
         3'd3: p = (za * zb) >> 32;
         3'd4: p = (b == 0) ? -64'sd1 : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? sa : sa / sb;
         3'd5: p = (b == 0) ? -64'sd1 : za / zb;
         3'd6: p = (b == 0) ? sa : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 64'sd0 : sa % sb;
         default: p = (b == 0) ? za : za % zb;
      endcase
      return p[31:0];
   endfunction

   function automatic int full_lat(input int k);
      return (32 >> k) + 2;
   endfunction

   // Issues one op on unit k; caller is at a negedge when now=1.
   task automatic do_op(input int k, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit now, input string name);
      int lat;
      logic [31:0] want;
      if (!now) @(negedge clock);
      req_op = op; rs1 = a; rs2 = b; req_valid[k] = 1'b1;
      exp_q.push_back(exp);
      n_cmp++;
      if (req_ready[k] !== 1'b1) begin
         n_err++; $display("FAIL %s_ready u%0d: got %b want 1", name, k, req_ready[k]);
      end
      @(posedge clock); #1 req_valid[k] = 1'b0;
      lat = 1;
      @(negedge clock);
      while (rsp_valid[k] !== 1'b1 && lat < 100) begin
         @(negedge clock); lat++;
      end
      want = exp_q.pop_front();
      n_cmp++;
      if (rsp_valid[k] !== 1'b1) begin
         n_err++; $display("FAIL %s_timeout u%0d: no rsp_valid after %0d cycles", name, k, lat);
      end else begin
         if (rsp_result[k] !== want) begin
            n_err++; $display("FAIL %s u%0d: got %h want %h", name, k, rsp_result[k], want);
         end
         n_cmp++;
         if (lat != exp_lat) begin
            n_err++; $display("FAIL %s_latency u%0d: got %0d want %0d", name, k, lat, exp_lat);
         end
      end
      @(posedge clock);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_result[k] !== 32'd0) begin
            n_err++;
            $display("FAIL reset u%0d: ready=%b valid=%b result=%h want 1/0/0", k, req_ready[k], rsp_valid[k], rsp_result[k]);
         end
      end
   endtask

   task automatic test_mul();
      for (int k = 0; k < 3; k++) begin
         do_op(k, 3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, full_lat(k), 0, "mul");
         do_op(k, 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, full_lat(k), 0, "mulh");
         do_op(k, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, full_lat(k), 0, "mulhu");
         do_op(k, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, full_lat(k), 0, "mulhsu");
      end
   endtask

   task automatic test_div();
      for (int k = 0; k < 3; k++) begin
         do_op(k, 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, full_lat(k), 0, "div");
         do_op(k, 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, full_lat(k), 0, "rem");
         do_op(k, 3'd5, 32'd100,      32'd7, 32'd14,       full_lat(k), 0, "divu");
         do_op(k, 3'd7, 32'd100,      32'd7, 32'd2,        full_lat(k), 0, "remu");
      end
   endtask

   task automatic test_shortcut();
      for (int k = 0; k < 3; k++) begin
         do_op(k, 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, "divu_by0");
         do_op(k, 3'd6, 32'd5,        32'd0,        32'd5,        1, 0, "rem_by0");
         do_op(k, 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, "div_ovf");
         do_op(k, 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0, "rem_ovf");
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 6; i++) begin
            op = 3'($urandom_range(7));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if ($signed(b) < 0 && i == 3) a = -a;
            do_op(k, op, a, b, model(op, a, b),
                  (op[2] && b == 0) ? 1 : full_lat(k), 0, "random");
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      for (int k = 0; k < 3; k++) begin
         rsp_ready[k] = 1'b0;
         @(negedge clock);
         req_op = 3'd5; rs1 = 32'd100; rs2 = 32'd7; req_valid[k] = 1'b1;
         exp_q.push_back(32'd14);
         @(posedge clock); #1 req_valid[k] = 1'b0;
         lat = 0;
         @(negedge clock);
         while (rsp_valid[k] !== 1'b1 && lat < 100) begin
            @(negedge clock); lat++;
         end
         begin
            logic [31:0] want;
            want = exp_q.pop_front();
            for (int c = 0; c < 5; c++) begin
               n_cmp++;
               if (rsp_valid[k] !== 1'b1 || req_ready[k] !== 1'b0 || rsp_result[k] !== want) begin
                  n_err++;
                  $display("FAIL backpressure u%0d c%0d: valid=%b ready=%b result=%h want 1/0/%h",
                           k, c, rsp_valid[k], req_ready[k], rsp_result[k], want);
               end
               if (c < 4) @(negedge clock);
            end
         end
         rsp_ready[k] = 1'b1;
         @(posedge clock);
         @(negedge clock);
         n_cmp++;
         if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0) begin
            n_err++; $display("FAIL after_handshake u%0d: ready=%b valid=%b want 1/0", k, req_ready[k], rsp_valid[k]);
         end
         do_op(k, 3'd0, 32'd11, 32'd13, 32'd143, full_lat(k), 1, "next_after_bp");
      end
   endtask

   task automatic test_flush();
      bit seen;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         req_op = 3'd0; rs1 = 32'd5; rs2 = 32'd6; req_valid[k] = 1'b1;
         @(posedge clock); #1 req_valid[k] = 1'b0;
         @(posedge clock); @(posedge clock);
         #1 flush[k] = 1'b1;
         @(posedge clock); #1 flush[k] = 1'b0;
         @(negedge clock);
         n_cmp++;
         if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0) begin
            n_err++; $display("FAIL flush_idle u%0d: ready=%b valid=%b want 1/0", k, req_ready[k], rsp_valid[k]);
         end
         seen = 0;
         for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rsp_valid[k] === 1'b1) seen = 1;
         end
         n_cmp++;
         if (seen) begin
            n_err++; $display("FAIL flush_discard u%0d: rsp_valid seen=1 want 0", k);
         end
         do_op(k, 3'd0, 32'd3, 32'd4, 32'd12, full_lat(k), 0, "mul_after_flush");
      end
   endtask

   task automatic test_async_reset();
      @(negedge clock);
      req_op = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
      for (int k = 0; k < 3; k++) req_valid[k] = 1'b1;
      @(posedge clock); #1;
      for (int k = 0; k < 3; k++) req_valid[k] = 1'b0;
      repeat (3) @(posedge clock);
      #2 resetn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (req_ready[k] !== 1'b1 || rsp_valid[k] !== 1'b0 || rsp_result[k] !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset u%0d: ready=%b valid=%b result=%h want 1/0/0", k, req_ready[k], rsp_valid[k], rsp_result[k]);
         end
      end
      @(negedge clock);
      resetn = 1'b1;
      for (int k = 0; k < 3; k++)
         do_op(k, 3'd7, 32'd50, 32'd8, 32'd2, full_lat(k), 0, "remu_after_reset");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 3; k++) begin
         flush[k] = 1'b0; req_valid[k] = 1'b0; rsp_ready[k] = 1'b1;
      end
      repeat (3) @(posedge clock);
      #1 test_reset();
      @(negedge clock) resetn = 1'b1;
      test_mul();
      test_div();
      test_shortcut();
      test_random();
      test_back_to_back();
      test_flush();
      test_async_reset();
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/xc_malu_mdu.md
# xc_malu_mdu

Parametrised iterative multiply/divide unit: the next generation of the XCrypto multi-cycle ALU datapath, with configurable operand width (`XLEN`) and bits retired per cycle (`RADIX_BITS`). It executes the RV M-extension operations with a valid/ready request/response handshake. It sits beside the XCrypto execute stage and replaces the fixed 32-bit, 1-bit-per-cycle mul/div path. It adds response back-pressure and single-cycle shortcuts for divide-by-zero and signed overflow.

## Interface
- `XLEN`, 32: operand and result width; must be a power of two, ≥8.
- `RADIX_BITS`, 1: multiplier/quotient bits processed per CALC cycle; one of 1, 2, 4; must divide `XLEN`.
- `clock`  in  1  single clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  abort any operation; synchronous.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  3  operation code (package enum).
- `req_rs1`  in  XLEN  dividend / multiplicand.
- `req_rs2`  in  XLEN  divisor / multiplier.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_result`  out  XLEN  result.

## Operation
- Op encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- States: IDLE, CALC, FIX, DONE.
- IDLE: `req_ready`=1. On `req_valid`, latch the operand magnitudes, result sign, op and clear the counter.
  - DIV/REM/DIVU/REMU with rs2==0 go directly to DONE with the shortcut result.
  - DIV/REM with rs1 == most-negative and rs2 == all-ones go directly to DONE with the shortcut result.
  - All other ops go to CALC.
- CALC, multiply: unsigned shift-add over `RADIX_BITS` multiplier bits per cycle into a 2·XLEN accumulator.
- CALC, divide: restoring division, `RADIX_BITS` chained subtract stages per cycle, building quotient and remainder.
- CALC exits to FIX after XLEN/RADIX_BITS cycles.
- FIX: two's-complement negation where required, then result selection.
  - MUL selects the low half; MULH, MULHSU and MULHU select the high half.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Quotient sign is rs1ˢ XOR rs2ˢ. Remainder takes rs1's sign.
  - MULHSU treats rs2 as unsigned.
- FIX → DONE.
- DONE: `rsp_valid`=1 and `rsp_result` is held stable until `rsp_ready`. On handshake → IDLE.
- Shortcut results:
  - Divide by zero: quotient all-ones, remainder = rs1.
  - Overflow: quotient = rs1, remainder = 0.
- `flush`: next state is IDLE from any state, and the in-flight result is discarded. Flush takes priority over request acceptance and over the response handshake in the same cycle.

## Timing
- Reset (async assert): state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_result`=0, all internal registers zero. A reset asserted mid-operation aborts immediately.
- Latency: if a request is accepted at edge 0, `rsp_valid` rises after edge XLEN/RADIX_BITS+2. For XLEN=32 this is 34 cycles at R=1 and 10 cycles at R=4.
- Shortcut latency: `rsp_valid` is high after edge 1.
- `req_ready` is combinationally equal to (state==IDLE). There is no request pipelining, so at most one operation is in flight.
- IDLE is re-entered one cycle after the response handshake, so back-to-back throughput is latency+1 cycles.
- `rsp_result` is registered and changes only on entry to DONE or on reset.

## Structure
- Package `xc_malu_mdu_pkg` holds:
  - the op enum (`MDU_OP_*`) and the state encoding;
  - functions `op_is_div`, `op_signed_rs1`, `op_signed_rs2`, `op_high`, `op_rem`.
- Sub-module `xc_malu_mdu_step`: a combinational single-cycle step, parametrised by `XLEN` and `RADIX_BITS`.
  - Inputs: accumulator, operand and mode.
  - Outputs: the next accumulator/quotient/remainder.
  - It contains the `RADIX_BITS` chained adders/subtractors.
- The top level holds the FSM, counter ($clog2(XLEN/RADIX_BITS) bits), registers, shortcut detection, sign fix-up and handshake.

## Test plan
- Run each scenario at XLEN=32 with RADIX_BITS = 1, 2 and 4.
- Multiply results:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - `rsp_valid` rises exactly 34/18/10 cycles after acceptance for R = 1/2/4.
- Signed divide: DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2.
- Shortcuts, each with `rsp_valid` one cycle after acceptance:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Back-pressure: hold `rsp_ready` low for 5 cycles in DONE → `rsp_result` stable, `rsp_valid`=1, `req_ready`=0. The next request is accepted one cycle after the handshake.
- Flush and reset:
  - Assert `flush` in CALC cycle 3 → IDLE next cycle with no `rsp_valid`. A following MUL 3×4 → 12.
  - Assert `resetn` low asynchronously mid-CALC → all outputs at reset values before the next edge.
